// File: rtl/task_out_packetizer.sv
// rtl/task_out_packetizer.sv - buffers task-core result words and replays them as one framed packet
module task_out_packetizer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WORDS  = 81,
    parameter int SIZE_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_input_last,
    input  logic                  i_tmanager_ready,
    output logic                  o_in_ready,
    output logic                  o_tanswer_ready,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tanswer_data_last,
    output logic [SIZE_WIDTH-1:0] o_packet_size_in_bytes,
    output logic                  o_busy,
    output logic                  o_full,
    output logic                  o_drop
);

    localparam int CW    = $clog2(MAX_WORDS + 1);
    localparam int PW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int BYTES = DATA_WIDTH / 8;

    generate
        if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
            $error("DATA_WIDTH must be a nonzero multiple of 8");
        end
        if (MAX_WORDS < 1) begin : g_bad_max_words
            $error("MAX_WORDS must be at least 1");
        end
        if (MAX_WORDS * BYTES >= (1 << SIZE_WIDTH)) begin : g_bad_size_width
            $error("SIZE_WIDTH too narrow for MAX_WORDS*DATA_WIDTH/8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [MAX_WORDS];
    logic                  in_ready_q;
    logic                  busy_q;
    logic                  drop_q;

    logic write_en;
    logic reaching_full;
    logic is_last;
    logic xfer;

    assign write_en      = i_data_valid && (state != ST_SEND);
    assign reaching_full = (count == CW'(MAX_WORDS - 1));
    assign is_last       = (state == ST_SEND) && (CW'(rd_ptr) == count - CW'(1));
    assign xfer          = (state == ST_SEND) && i_tmanager_ready;

    // Storage carries no reset; words past count are never read.
    always_ff @(posedge i_clk) begin
        if (write_en) begin
            mem[count[PW-1:0]] <= i_data;
        end
    end

    // in_ready/busy are registered from the next state so they read 0 during reset
    // and track the state from the first edge after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= i_data_valid && (state == ST_SEND);
            case (state)
                ST_IDLE: begin
                    if (write_en) begin
                        count  <= count + CW'(1);
                        busy_q <= 1'b1;
                        if (i_input_last || reaching_full) begin
                            state      <= ST_SEND;
                            in_ready_q <= 1'b0;
                        end else begin
                            state      <= ST_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    busy_q <= 1'b1;
                    if (write_en) begin
                        count <= count + CW'(1);
                    end
                    if (i_input_last || (write_en && reaching_full)) begin
                        state      <= ST_SEND;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (xfer && is_last) begin
                        state      <= ST_IDLE;
                        count      <= '0;
                        rd_ptr     <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        if (xfer) begin
                            rd_ptr <= rd_ptr + PW'(1);
                        end
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    count      <= '0;
                    rd_ptr     <= '0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready             = in_ready_q;
    assign o_busy                 = busy_q;
    assign o_drop                 = drop_q;
    assign o_tanswer_ready        = (state == ST_SEND);
    assign o_tdata                = mem[rd_ptr];
    assign o_tanswer_data_last    = is_last;
    assign o_full                 = (count == CW'(MAX_WORDS));
    assign o_packet_size_in_bytes = (state == ST_SEND)
                                  ? SIZE_WIDTH'(count) * SIZE_WIDTH'(BYTES)
                                  : '0;

endmodule

// File: tb/tb_task_out_packetizer.sv
// tb/tb_task_out_packetizer.sv - directed self-checking bench for task_out_packetizer
module tb_task_out_packetizer;

    logic        clk;
    logic        rst_n;

    logic [7:0]  data_a;
    logic        valid_a, last_a, tm_a;
    logic        in_ready_a, tans_a, tlast_a, busy_a, full_a, drop_a;
    logic [7:0]  tdata_a;
    logic [11:0] size_a;

    logic [31:0] data_b;
    logic        valid_b, last_b, tm_b;
    logic        in_ready_b, tans_b, tlast_b, busy_b, full_b, drop_b;
    logic [31:0] tdata_b;
    logic [11:0] size_b;

    int checks = 0;
    int errors = 0;

    task_out_packetizer #(.DATA_WIDTH(8), .MAX_WORDS(81), .SIZE_WIDTH(12)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data_a), .i_data_valid(valid_a),
        .i_input_last(last_a), .i_tmanager_ready(tm_a), .o_in_ready(in_ready_a),
        .o_tanswer_ready(tans_a), .o_tdata(tdata_a), .o_tanswer_data_last(tlast_a),
        .o_packet_size_in_bytes(size_a), .o_busy(busy_a), .o_full(full_a), .o_drop(drop_a)
    );

    task_out_packetizer #(.DATA_WIDTH(32), .MAX_WORDS(4), .SIZE_WIDTH(12)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data_b), .i_data_valid(valid_b),
        .i_input_last(last_b), .i_tmanager_ready(tm_b), .o_in_ready(in_ready_b),
        .o_tanswer_ready(tans_b), .o_tdata(tdata_b), .o_tanswer_data_last(tlast_b),
        .o_packet_size_in_bytes(size_b), .o_busy(busy_b), .o_full(full_b), .o_drop(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready_a, tans_a, tlast_a, busy_a, full_a, drop_a} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags_a: got %b expected 000000",
                     {in_ready_a, tans_a, tlast_a, busy_a, full_a, drop_a});
        end
        checks++;
        if (size_a !== 12'd0) begin
            errors++;
            $display("FAIL reset_size_a: got %0d expected 0", size_a);
        end
        checks++;
        if ({in_ready_b, tans_b, busy_b} !== 3'b0) begin
            errors++;
            $display("FAIL reset_flags_b: got %b expected 000", {in_ready_b, tans_b, busy_b});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b0 || in_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got in_ready_a=%b busy_a=%b in_ready_b=%b expected 1 0 1",
                     in_ready_a, busy_a, in_ready_b);
        end
    endtask

    task automatic test_full_packet;
        tm_a = 1'b1;
        for (int i = 0; i < 81; i++) begin
            data_a = 8'(i); valid_a = 1'b1; last_a = 1'b0;
            tick();
            if (i == 40) begin
                checks++;
                if (size_a !== 12'd0 || in_ready_a !== 1'b1 || busy_a !== 1'b1 || tans_a !== 1'b0) begin
                    errors++;
                    $display("FAIL load_status: got size=%0d in_ready=%b busy=%b tans=%b expected 0 1 1 0",
                             size_a, in_ready_a, busy_a, tans_a);
                end
            end
        end
        valid_a = 1'b0;
        checks++;
        if (tans_a !== 1'b1 || size_a !== 12'd81 || full_a !== 1'b1 || in_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL full_send_entry: got tans=%b size=%0d full=%b in_ready=%b expected 1 81 1 0",
                     tans_a, size_a, full_a, in_ready_a);
        end
        for (int i = 0; i < 81; i++) begin
            checks++;
            if (tdata_a !== 8'(i) || tlast_a !== (i == 80)) begin
                errors++;
                $display("FAIL full_word[%0d]: got data=%0d last=%b expected data=%0d last=%b",
                         i, tdata_a, tlast_a, i, (i == 80));
            end
            tick();
        end
        checks++;
        if (tans_a !== 1'b0 || busy_a !== 1'b0 || size_a !== 12'd0 || full_a !== 1'b0 || in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL full_back_idle: got tans=%b busy=%b size=%0d full=%b in_ready=%b expected 0 0 0 0 1",
                     tans_a, busy_a, size_a, full_a, in_ready_a);
        end
    endtask

    task automatic test_short_packet;
        tm_a = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            for (int w = 0; w < 5; w++) begin
                data_a = 8'(10 + w); valid_a = 1'b1; last_a = (rep == 0 && w == 4);
                tick();
            end
            valid_a = 1'b0; last_a = 1'b0;
            if (rep == 1) begin
                last_a = 1'b1;
                tick();
                last_a = 1'b0;
            end
            checks++;
            if (tans_a !== 1'b1 || size_a !== 12'd5) begin
                errors++;
                $display("FAIL short_entry[%0d]: got tans=%b size=%0d expected 1 5", rep, tans_a, size_a);
            end
            for (int w = 0; w < 5; w++) begin
                checks++;
                if (tdata_a !== 8'(10 + w) || tlast_a !== (w == 4)) begin
                    errors++;
                    $display("FAIL short_word[%0d][%0d]: got data=%0d last=%b expected data=%0d last=%b",
                             rep, w, tdata_a, tlast_a, 10 + w, (w == 4));
                end
                tick();
            end
            checks++;
            if (tans_a !== 1'b0) begin
                errors++;
                $display("FAIL short_idle[%0d]: got tans=%b expected 0", rep, tans_a);
            end
        end
    endtask

    task automatic test_backpressure;
        int idx;
        int k;
        tm_a = 1'b0;
        for (int w = 0; w < 6; w++) begin
            data_a = 8'(8'h20 + w); valid_a = 1'b1; last_a = (w == 5);
            tick();
        end
        valid_a = 1'b0; last_a = 1'b0;
        idx = 0;
        k = 0;
        while (idx < 6 && k < 40) begin
            tm_a = (k % 3 == 0);
            checks++;
            if (tdata_a !== 8'(8'h20 + idx) || tlast_a !== (idx == 5)) begin
                errors++;
                $display("FAIL bp_word[cycle %0d]: got data=%h last=%b expected data=%h last=%b",
                         k, tdata_a, tlast_a, 8'(8'h20 + idx), (idx == 5));
            end
            if (tm_a) idx++;
            tick();
            k++;
        end
        checks++;
        if (idx != 6 || tans_a !== 1'b0) begin
            errors++;
            $display("FAIL bp_complete: got transfers=%0d tans=%b expected 6 0", idx, tans_a);
        end
        tm_a = 1'b1;
    endtask

    task automatic test_drop_and_idle_last;
        valid_a = 1'b0; last_a = 1'b1;
        tick();
        last_a = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0 || tans_a !== 1'b0 || in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL idle_last_ignored: got busy=%b tans=%b in_ready=%b expected 0 0 1",
                     busy_a, tans_a, in_ready_a);
        end
        tm_a = 1'b0;
        for (int w = 0; w < 3; w++) begin
            data_a = 8'(8'h40 + w); valid_a = 1'b1; last_a = (w == 2);
            tick();
        end
        valid_a = 1'b0; last_a = 1'b0;
        checks++;
        if (size_a !== 12'd3 || drop_a !== 1'b0) begin
            errors++;
            $display("FAIL drop_entry: got size=%0d drop=%b expected 3 0", size_a, drop_a);
        end
        data_a = 8'hFF; valid_a = 1'b1; last_a = 1'b1;
        tick();
        valid_a = 1'b0; last_a = 1'b0;
        checks++;
        if (drop_a !== 1'b1 || size_a !== 12'd3 || tans_a !== 1'b1 || tdata_a !== 8'h40) begin
            errors++;
            $display("FAIL drop_pulse: got drop=%b size=%0d tans=%b data=%h expected 1 3 1 40",
                     drop_a, size_a, tans_a, tdata_a);
        end
        tick();
        checks++;
        if (drop_a !== 1'b0) begin
            errors++;
            $display("FAIL drop_width: got drop=%b expected 0", drop_a);
        end
        tm_a = 1'b1;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (tdata_a !== 8'(8'h40 + w) || tlast_a !== (w == 2)) begin
                errors++;
                $display("FAIL drop_word[%0d]: got data=%h last=%b expected data=%h last=%b",
                         w, tdata_a, tlast_a, 8'(8'h40 + w), (w == 2));
            end
            tick();
        end
        checks++;
        if (tans_a !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got tans=%b expected 0", tans_a);
        end
    endtask

    task automatic test_reset_mid_send;
        tm_a = 1'b1;
        for (int w = 0; w < 5; w++) begin
            data_a = 8'(8'h50 + w); valid_a = 1'b1; last_a = (w == 4);
            tick();
        end
        valid_a = 1'b0; last_a = 1'b0;
        tick();
        tick();
        checks++;
        if (tdata_a !== 8'h52 || tans_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_state: got data=%h tans=%b expected 52 1", tdata_a, tans_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tans_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b0 || size_a !== 12'd0) begin
            errors++;
            $display("FAIL rst_async: got tans=%b busy=%b in_ready=%b size=%0d expected 0 0 0 0",
                     tans_a, busy_a, in_ready_a, size_a);
        end
        tick();
        rst_n = 1'b1;
        tick();
        for (int w = 0; w < 3; w++) begin
            data_a = 8'(8'h60 + w); valid_a = 1'b1; last_a = (w == 2);
            tick();
        end
        valid_a = 1'b0; last_a = 1'b0;
        checks++;
        if (size_a !== 12'd3 || tdata_a !== 8'h60) begin
            errors++;
            $display("FAIL rst_next_packet: got size=%0d data=%h expected 3 60", size_a, tdata_a);
        end
        for (int w = 0; w < 3; w++) tick();
        checks++;
        if (tans_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_next_idle: got tans=%b expected 0", tans_a);
        end
    endtask

    task automatic test_width;
        tm_b = 1'b1;
        for (int w = 0; w < 3; w++) begin
            data_b = 32'h1111_1111 * 32'(w + 1); valid_b = 1'b1; last_b = 1'b0;
            tick();
        end
        valid_b = 1'b0; last_b = 1'b1;
        tick();
        last_b = 1'b0;
        checks++;
        if (size_b !== 12'd12 || tans_b !== 1'b1) begin
            errors++;
            $display("FAIL width_size: got size=%0d tans=%b expected 12 1", size_b, tans_b);
        end
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (tdata_b !== 32'h1111_1111 * 32'(w + 1) || tlast_b !== (w == 2)) begin
                errors++;
                $display("FAIL width_word[%0d]: got data=%h last=%b expected data=%h last=%b",
                         w, tdata_b, tlast_b, 32'h1111_1111 * 32'(w + 1), (w == 2));
            end
            tick();
        end
        for (int w = 0; w < 4; w++) begin
            data_b = 32'hA000_0000 + 32'(w); valid_b = 1'b1;
            tick();
        end
        valid_b = 1'b0;
        checks++;
        if (size_b !== 12'd16 || full_b !== 1'b1 || tans_b !== 1'b1) begin
            errors++;
            $display("FAIL width_full: got size=%0d full=%b tans=%b expected 16 1 1", size_b, full_b, tans_b);
        end
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (tdata_b !== 32'hA000_0000 + 32'(w) || tlast_b !== (w == 3)) begin
                errors++;
                $display("FAIL width_full_word[%0d]: got data=%h last=%b expected data=%h last=%b",
                         w, tdata_b, tlast_b, 32'hA000_0000 + 32'(w), (w == 3));
            end
            tick();
        end
        checks++;
        if (full_b !== 1'b0 || tans_b !== 1'b0) begin
            errors++;
            $display("FAIL width_idle: got full=%b tans=%b expected 0 0", full_b, tans_b);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        data_a = '0; valid_a = 1'b0; last_a = 1'b0; tm_a = 1'b0;
        data_b = '0; valid_b = 1'b0; last_b = 1'b0; tm_b = 1'b0;
        test_reset();
        test_full_packet();
        test_short_packet();
        test_backpressure();
        test_drop_and_idle_last();
        test_reset_mid_send();
        test_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
